serial_tx_shifter: RTL and testbench
====================================

# serial_tx_shifter

Upstream stimulus stage for the serial pattern detector. It accepts parallel words over a valid/ready handshake and serializes each one MSB-first, one bit per sys_clk. Its dat_out drives the detector's dat_in directly. A one-word holding buffer lets consecutive words go out back-to-back with no idle bits between them. When idle, the line sits at a fixed level so the detector never sees a stray pattern.

## Interface
- WIDTH, 8: word width in bits; legal values 2..16.
- IDLE_BIT, 1'b0: level driven on dat_out when no word is being shifted.
- sys_clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  parallel word, MSB transmitted first.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  holding buffer is empty; equals !hold_full, combinational from a register only.
- dat_out  out  1  serial bit stream (registered); feeds the detector's dat_in.
- bit_valid  out  1  dat_out carries a payload bit this cycle (registered).
- frame_done  out  1  one-cycle pulse, high in the same cycle as the last bit (LSB) of each word.
- busy  out  1  shifter is in SHIFT or the holding buffer is full.

## Operation
- Internal storage:
  - hold_reg[WIDTH-1:0] and hold_full: the one-word buffer.
  - shift_reg[WIDTH-1:0]: the word being serialized.
  - bit_cnt: width clog2(WIDTH); counts 0..WIDTH-1 and never exceeds WIDTH-1.
  - state: IDLE or SHIFT.
- Handshake:
  - A transfer occurs at a rising edge where din_valid && din_ready.
  - On transfer: hold_reg <= din, hold_full <= 1.
  - din is ignored when din_ready=0; the sender must hold din/din_valid until it is accepted.
- IDLE:
  - If hold_full: load shift_reg <= hold_reg, clear hold_full, dat_out <= hold_reg[WIDTH-1], bit_valid <= 1, bit_cnt <= 0, go to SHIFT.
  - Otherwise: dat_out <= IDLE_BIT, bit_valid <= 0.
- SHIFT, bit_cnt < WIDTH-1:
  - shift_reg shifts left by 1.
  - dat_out <= next bit.
  - bit_cnt++.
  - frame_done <= 1 when the bit being loaded is the LSB, i.e. bit_cnt becomes WIDTH-1.
- SHIFT, bit_cnt == WIDTH-1 (last bit is on dat_out):
  - If hold_full: reload from hold_reg exactly as in IDLE and stay in SHIFT. This is gapless; bit_valid stays 1.
  - Otherwise: dat_out <= IDLE_BIT, bit_valid <= 0, go to IDLE.
- Same-edge events:
  - A transfer and a reload cannot collide, because a transfer requires hold_full=0 and a reload requires hold_full=1.
  - Reload and a new transfer therefore happen on different edges.
- busy = (state==SHIFT) | hold_full.
- Reset, including mid-frame: the current word and any held word are discarded; nothing resumes after release.
- Reset values:
  - dat_out=IDLE_BIT, bit_valid=0, frame_done=0.
  - busy=0, din_ready=1.
  - state=IDLE, bit_cnt=0, hold_full=0.

## Timing
- Latency: transfer at edge k. First bit (MSB) appears on dat_out after edge k+1, with bit_valid=1. The LSB appears after edge k+WIDTH, with frame_done=1.
- din_ready deasserts after edge k and reasserts after edge k+1, when the shifter takes the word. This holds only if the shifter was IDLE. If the shifter was busy, din_ready reasserts one edge after the current word's last bit, when the reload happens.
- Sustained throughput: one word per WIDTH cycles with zero idle bits, provided the next word is transferred at least one edge before the current word's last bit completes.
- frame_done is never high for two consecutive cycles when WIDTH ≥ 2.
- There is no combinational path from din or din_valid to any output.

## Test plan
- Reset:
  - Stimulus: hold rst=0 for 3 cycles, then release.
  - Required: dat_out=0, bit_valid=0, frame_done=0, busy=0, din_ready=1.
  - With din_valid=0 for 10 cycles, all outputs remain unchanged.
- Single word, WIDTH=8:
  - Stimulus: din=8'hD0, transferred at edge k.
  - Required: dat_out over cycles k+1..k+8 is 1,1,0,1,0,0,0,0.
  - frame_done high only in cycle k+8.
  - dat_out returns to 0 and bit_valid to 0 in cycle k+9.
  - With this output connected to the detector, find rises exactly once.
- Back-to-back:
  - Stimulus: words 8'hA5 then 8'h3C, din_valid held high.
  - Required: 16 consecutive bits 10100101_00111100 with bit_valid continuously high.
  - Two frame_done pulses, in cycles k+8 and k+16.
  - din_ready low while the holding buffer is full.
- Backpressure:
  - Stimulus: present three words with din_valid stuck at 1.
  - Required: the third word is accepted only in the cycle after the first word's LSB.
  - No word is lost or duplicated; the output bit stream exactly matches the input words in order.
- Reset mid-frame:
  - Stimulus: assert rst after bit 3 of 8'hFF while 8'h0F is held.
  - Required: outputs return to reset values immediately.
  - After release with no new input, no further bit_valid appears.
- Parameters:
  - Stimulus: WIDTH=4, IDLE_BIT=1, word 4'b1101.
  - Required: idle line is 1; payload bits are 1,1,0,1; frame_done appears on the 4th bit.

Source files
------------

// File: rtl/serial_tx_if.sv
// Parallel-word handshake and serial output bundle shared by the transmit shifter and its sender.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dat_out;
  logic             bit_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, dat_out, bit_valid, frame_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dat_out, bit_valid, frame_done, busy
  );
endinterface

// File: rtl/serial_tx_shifter.sv
// Serializes parallel words MSB-first, one bit per sys_clk, through a one-word holding buffer
// so consecutive words leave back-to-back with no idle bits.
module serial_tx_shifter #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input logic        sys_clk,
  input logic        rst,
  serial_tx_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_r, state_s;
  logic [WIDTH-1:0] hold_r, hold_s;
  logic             hold_full_r, hold_full_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic             dat_r, dat_s;
  logic             vld_r, vld_s;
  logic             fd_r, fd_s;
  logic             busy_r, busy_s;
  logic             load_s;

  // Next-state decode for the shifter FSM, holding buffer and serial outputs.
  always_comb begin
    state_s     = state_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    dat_s       = IDLE_BIT;
    vld_s       = 1'b0;
    fd_s        = 1'b0;
    load_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r != CNT_LAST) begin
          shift_s   = shift_r << 1'b1;
          dat_s     = shift_r[WIDTH-2];
          vld_s     = 1'b1;
          bit_cnt_s = bit_cnt_r + CNT_ONE;
          fd_s      = (bit_cnt_r == CNT_PRE);
        end else if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A reload needs hold_full=1 and a transfer needs hold_full=0, so the two never share an edge.
    if (load_s) begin
      shift_s     = hold_r;
      hold_full_s = 1'b0;
      dat_s       = hold_r[WIDTH-1];
      vld_s       = 1'b1;
      bit_cnt_s   = CNT_ZERO;
      state_s     = ST_SHIFT;
    end else if (bus.din_valid && !hold_full_r) begin
      hold_s      = bus.din;
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_s;
    end

    busy_s = (state_s == ST_SHIFT) | hold_full_s;
  end

  // State and output registers; reset discards both the word in flight and any held word.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      shift_r     <= {WIDTH{1'b0}};
      bit_cnt_r   <= CNT_ZERO;
      dat_r       <= IDLE_BIT;
      vld_r       <= 1'b0;
      fd_r        <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      dat_r       <= dat_s;
      vld_r       <= vld_s;
      fd_r        <= fd_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.din_ready  = ~hold_full_r;
  assign bus.dat_out    = dat_r;
  assign bus.bit_valid  = vld_r;
  assign bus.frame_done = fd_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed self-checking bench for serial_tx_shifter: an 8-bit/idle-0 instance and a 4-bit/idle-1 instance.
module tb_serial_tx_shifter;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  serial_tx_if #(.WIDTH(8)) bus8 ();
  serial_tx_if #(.WIDTH(4)) bus4 ();

  serial_tx_shifter #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus8)
  );

  serial_tx_shifter #(.WIDTH(4), .IDLE_BIT(1'b1)) u4 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus4)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] wq [3];
  int acc_cyc [3];

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] st8();
    return {bus8.dat_out, bus8.bit_valid, bus8.frame_done, bus8.busy, bus8.din_ready};
  endfunction

  function automatic logic [4:0] st4();
    return {bus4.dat_out, bus4.bit_valid, bus4.frame_done, bus4.busy, bus4.din_ready};
  endfunction

  // Sends n words from wq with din_valid held until each is accepted, then checks the bit stream.
  task automatic run_stream(input int n);
    int   idx;
    int   j;
    logic acc;
    idx = 0;
    for (int i = 0; i < 3; i++) acc_cyc[i] = -1;
    bus8.din       = wq[0];
    bus8.din_valid = 1'b1;
    for (int c = 1; c <= 8 * n + 3; c++) begin
      acc = bus8.din_valid && bus8.din_ready;
      tick();
      if (acc) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < n) bus8.din = wq[idx];
        else bus8.din_valid = 1'b0;
      end
      if (c >= 2 && c <= 1 + 8 * n) begin
        j = c - 2;
        check("stream_bit", 16'(bus8.dat_out), 16'(wq[j / 8][7 - (j % 8)]));
        check("stream_valid", 16'(bus8.bit_valid), 16'd1);
        check("stream_frame_done", 16'(bus8.frame_done), 16'((j % 8) == 7));
      end else if (c > 1 + 8 * n) begin
        check("stream_tail", 16'({bus8.bit_valid, bus8.dat_out, bus8.busy}), 16'd0);
      end
    end
    check("accept_count", 16'(idx), 16'(n));
  endtask

  initial begin
    logic [7:0] w8;
    logic [3:0] w4;
    bus8.din = 8'h00;
    bus8.din_valid = 1'b0;
    bus4.din = 4'h0;
    bus4.din_valid = 1'b0;

    // Reset held for three cycles, then ten idle cycles after release.
    rst = 1'b0;
    repeat (3) tick();
    check("reset_state_w8", 16'(st8()), 16'(5'b00001));
    check("reset_state_w4", 16'(st4()), 16'(5'b10001));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_w8", 16'(st8()), 16'(5'b00001));
      check("idle_w4", 16'(st4()), 16'(5'b10001));
    end

    // Single word 8'hD0.
    w8 = 8'hD0;
    bus8.din = w8;
    bus8.din_valid = 1'b1;
    tick();
    bus8.din_valid = 1'b0;
    check("single_ready_low", 16'(bus8.din_ready), 16'd0);
    check("single_busy", 16'(bus8.busy), 16'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("single_bit", 16'(bus8.dat_out), 16'(w8[7 - i]));
      check("single_valid", 16'(bus8.bit_valid), 16'd1);
      check("single_frame_done", 16'(bus8.frame_done), 16'(i == 7));
      if (i == 0) check("single_ready_back", 16'(bus8.din_ready), 16'd1);
    end
    tick();
    check("single_after", 16'(st8()), 16'(5'b00001));

    // Back-to-back: 8'hA5 then 8'h3C.
    wq[0] = 8'hA5;
    wq[1] = 8'h3C;
    wq[2] = 8'h00;
    run_stream(2);
    check("b2b_accept0", 16'(acc_cyc[0]), 16'd1);
    check("b2b_accept1", 16'(acc_cyc[1]), 16'd3);

    // Backpressure: three words with din_valid stuck high.
    wq[0] = 8'h96;
    wq[1] = 8'h4B;
    wq[2] = 8'hE1;
    run_stream(3);
    check("bp_accept0", 16'(acc_cyc[0]), 16'd1);
    check("bp_accept1", 16'(acc_cyc[1]), 16'd3);
    check("bp_accept2", 16'(acc_cyc[2]), 16'd11);

    // Reset after bit 3 of 8'hFF while 8'h0F sits in the holding buffer.
    bus8.din = 8'hFF;
    bus8.din_valid = 1'b1;
    tick();
    bus8.din = 8'h0F;
    tick();
    tick();
    bus8.din_valid = 1'b0;
    check("midframe_held", 16'({bus8.din_ready, bus8.busy}), 16'(2'b01));
    tick();
    tick();
    check("midframe_bit3", 16'({bus8.dat_out, bus8.bit_valid}), 16'(2'b11));
    rst = 1'b0;
    #1;
    check("midframe_reset", 16'(st8()), 16'(5'b00001));
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_reset_quiet", 16'(st8()), 16'(5'b00001));
    end

    // WIDTH=4 / IDLE_BIT=1 instance, word 4'b1101.
    w4 = 4'b1101;
    check("w4_idle_line", 16'(bus4.dat_out), 16'd1);
    bus4.din = w4;
    bus4.din_valid = 1'b1;
    tick();
    bus4.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w4_bit", 16'(bus4.dat_out), 16'(w4[3 - i]));
      check("w4_valid", 16'(bus4.bit_valid), 16'd1);
      check("w4_frame_done", 16'(bus4.frame_done), 16'(i == 3));
    end
    tick();
    check("w4_after", 16'(st4()), 16'(5'b10001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
